countdown_timer8: RTL and testbench

//  Loadable down-counter with a built-in tick prescaler, pause, and a one-cycle

---
 rtl/countdown_timer8.sv | 163 ++++++++++++++++
 tb/tb_countdown_timer8.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer8.sv
// countdown_timer8
// Loadable down-counter with an internal tick prescaler, level pause and a
// one-cycle expiry pulse. A loaded value decrements once every PRESCALE
// cycles of forward progress. On reaching zero the block reports expiry and
// holds there until it is acknowledged or reloaded.
module countdown_timer8 #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 50000,
  parameter int PS_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             done
);

  // Binary state encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;
  localparam logic [1:0] ST_EXPIRED = 2'b11;

  // The prescaler wraps when it reaches PS_LAST; that edge is a decrement tick.
  // With PRESCALE == 1, PS_LAST is zero, so every progressing cycle ticks and
  // the prescaler never leaves zero.
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ZERO  = {PS_W{1'b0}};
  localparam logic [PS_W-1:0]  PS_ONE   = {{(PS_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [PS_W-1:0]  ps_r;
  logic [PS_W-1:0]  ps_nxt_s;
  logic [PS_W-1:0]  ps_step_s;
  logic [WIDTH-1:0] remaining_r;
  logic [WIDTH-1:0] remaining_nxt_s;
  logic [WIDTH-1:0] remaining_step_s;
  logic             tick_s;
  logic             reach_zero_s;
  logic             entry_s;

  // Values the counters take on a cycle of forward progress (RUN, pause low).
  always_comb begin
    tick_s = (ps_r == PS_LAST);
    if (tick_s) begin
      ps_step_s = PS_ZERO;
    end else begin
      ps_step_s = ps_r + PS_ONE;
    end
    // A zero count never decrements further, so the counter cannot wrap.
    if (tick_s && (remaining_r != CNT_ZERO)) begin
      remaining_step_s = remaining_r - CNT_ONE;
    end else begin
      remaining_step_s = remaining_r;
    end
    // Expiry when this progress step lands on zero (or, defensively, when a
    // progressing count is somehow already zero).
    if (remaining_r == CNT_ZERO) begin
      reach_zero_s = 1'b1;
    end else if (tick_s && (remaining_r == CNT_ONE)) begin
      reach_zero_s = 1'b1;
    end else begin
      reach_zero_s = 1'b0;
    end
  end

  // Next-state and counter update; load outranks ack, which outranks pause,
  // which outranks the tick.
  always_comb begin
    state_nxt_s     = state_r;
    ps_nxt_s        = ps_r;
    remaining_nxt_s = remaining_r;
    entry_s         = 1'b0;
    if (load) begin
      remaining_nxt_s = load_value;
      ps_nxt_s        = PS_ZERO;
      if (load_value == CNT_ZERO) begin
        state_nxt_s = ST_EXPIRED;
        entry_s     = 1'b1;
      end else begin
        // A load with pause high still starts in RUN; pause takes effect on
        // the following edge.
        state_nxt_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            // Freeze: the edge that enters PAUSED does not decrement.
            state_nxt_s = ST_PAUSED;
          end else begin
            // Leaving PAUSED progresses on the same edge, so the delay equals
            // exactly the number of edges pause was sampled high.
            ps_nxt_s        = ps_step_s;
            remaining_nxt_s = remaining_step_s;
            if (reach_zero_s) begin
              state_nxt_s = ST_EXPIRED;
              entry_s     = 1'b1;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end
        end
        ST_EXPIRED: begin
          // pause has no meaning here; only ack (to IDLE) or load moves on.
          if (ack) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_EXPIRED;
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          ps_nxt_s        = PS_ZERO;
          remaining_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State and counter registers; reset abandons any count in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ps_r        <= PS_ZERO;
      remaining_r <= CNT_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      ps_r        <= ps_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  // Registered status flags decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      paused  <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      running <= (state_nxt_s == ST_RUN);
      paused  <= (state_nxt_s == ST_PAUSED);
      expired <= entry_s;
      done    <= (state_nxt_s == ST_EXPIRED);
    end
  end

  assign remaining = remaining_r;

endmodule

// File: tb/tb_countdown_timer8.sv
// Testbench for countdown_timer8 (PRESCALE=4). A reference model counts
// cycles of forward progress since the last load; remaining is the loaded
// value minus whole prescale periods elapsed. Expected observations are queued
// on every edge and a separate monitor compares them on the falling edge.
module tb_countdown_timer8;

  localparam int W = 8;
  localparam int P = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_EXP    = 3;

  typedef struct packed {
    logic [W-1:0] rem;
    logic         run;
    logic         pau;
    logic         exp;
    logic         dn;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         pause;
  logic         ack;
  logic [W-1:0] remaining;
  logic         running;
  logic         paused;
  logic         expired;
  logic         done;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];
  bit   mon_on = 1'b0;

  int m_mode  = M_IDLE;
  int m_len   = 0;
  int m_prog  = 0;
  bit m_pulse = 1'b0;

  countdown_timer8 #(.WIDTH(W), .PRESCALE(P), .PS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .pause      (pause),
    .ack        (ack),
    .remaining  (remaining),
    .running    (running),
    .paused     (paused),
    .expired    (expired),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.rem = W'(m_len - (m_prog / P));
    o.run = (m_mode == M_RUN);
    o.pau = (m_mode == M_PAUSED);
    o.exp = m_pulse;
    o.dn  = (m_mode == M_EXP);
    return o;
  endfunction

  // Reference model: advances on each clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode  = M_IDLE;
        m_len   = 0;
        m_prog  = 0;
        m_pulse = 1'b0;
        exp_q.delete();
      end else begin
        m_pulse = 1'b0;
        if (load) begin
          m_len  = int'(load_value);
          m_prog = 0;
          if (m_len == 0) begin
            m_mode  = M_EXP;
            m_pulse = 1'b1;
          end else begin
            m_mode = M_RUN;
          end
        end else if (m_mode == M_EXP) begin
          if (ack) m_mode = M_IDLE;
        end else if (m_mode == M_RUN || m_mode == M_PAUSED) begin
          if (pause) begin
            m_mode = M_PAUSED;
          end else begin
            m_mode = M_RUN;
            m_prog = m_prog + 1;
            if (m_prog >= m_len * P) begin
              m_mode  = M_EXP;
              m_pulse = 1'b1;
            end
          end
        end
      end
      exp_q.push_back(model_obs());
    end
  end

  // Monitor: compare DUT outputs against the newest expectation each cycle.
  initial begin
    obs_t got;
    obs_t want;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
        end else begin
          want = exp_q[$];
          exp_q.delete();
          got = {remaining, running, paused, expired, done};
          if (got !== want) begin
            bad = bad + 1;
            $display("FAIL scoreboard t=%0t got rem=%0d run=%b pau=%b exp=%b done=%b want rem=%0d run=%b pau=%b exp=%b done=%b",
                     $time, got.rem, got.run, got.pau, got.exp, got.dn,
                     want.rem, want.run, want.pau, want.exp, want.dn);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Apply inputs for one edge; returns 2ns after that edge.
  task automatic drive(input bit l, input int lv, input bit p, input bit a);
    load       = l;
    load_value = W'(lv);
    pause      = p;
    ack        = a;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit plvl;
    reset = 1'b0; load = 1'b0; load_value = '0; pause = 1'b0; ack = 1'b0;
    #1;
    reset = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", int'({remaining, running, paused, expired, done}), 0);
    reset = 1'b0;
    drive(0, 0, 1, 1);

    // load 3: expiry 12 edges after the load edge, done held until ack
    drive(1, 3, 0, 0);
    chk("load3_initial", int'(remaining), 3);
    n = -1;
    for (int e = 1; e <= 40; e++) begin
      drive(0, 0, 0, 0);
      if (e == 4) chk("load3_after4", int'(remaining), 2);
      if (expired) begin n = e; break; end
    end
    chk("load3_expiry_edge", n, 12);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("done_held", int'(done), 1);
    drive(0, 0, 0, 1);
    chk("ack_clears_done", int'(done), 0);

    // load 0 expires immediately, then ack and ignored inputs in IDLE
    drive(1, 0, 0, 0);
    chk("load0_pulse", int'({expired, done, remaining}), 'h300);
    drive(0, 0, 0, 0);
    chk("load0_pulse_once", int'({expired, done}), 1);
    drive(0, 0, 0, 1);
    chk("load0_ack_idle", int'({running, paused, done}), 0);
    drive(0, 0, 1, 1);
    chk("idle_ack_pause", int'({running, paused, done}), 0);
    drive(1, 2, 0, 1);
    chk("load_beats_ack", int'({running, remaining}), 'h102);

    // load 2 with pause sampled high on edges k+2..k+7: expiry at k+14
    drive(1, 2, 0, 0);
    n = -1;
    for (int e = 1; e <= 40; e++) begin
      drive(0, 0, (e >= 2 && e <= 7), 0);
      if (e == 4) chk("pause_window_flag", int'(paused), 1);
      if (expired) begin n = e; break; end
    end
    chk("pause_expiry_edge", n, 14);

    // load 5, reload 2 at k+6: expiry at k+14, no earlier pulse
    drive(1, 5, 0, 0);
    n = -1;
    for (int e = 1; e <= 40; e++) begin
      drive((e == 6), 2, 0, 0);
      if (e == 6) chk("reload_value", int'(remaining), 2);
      if (expired) begin n = e; break; end
    end
    chk("reload_expiry_edge", n, 14);

    // asynchronous reset in the middle of a run
    drive(1, 6, 0, 0);
    repeat (9) drive(0, 0, 0, 0);
    chk("pre_reset_remaining", int'(remaining), 4);
    reset = 1'b1;
    #1;
    chk("reset_async", int'({remaining, running, paused, expired, done}), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) drive(0, 0, 0, 0);
    chk("reset_no_pulse", int'({remaining, running, expired, done}), 0);

    // randomized traffic checked by the scoreboard
    plvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) plvl = ~plvl;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
      end else begin
        drive(($urandom_range(0, 13) == 0), int'($urandom_range(0, 5)), plvl,
              ($urandom_range(0, 4) == 0));
      end
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
